// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU opcode constants and execute-stage storage states.
// Used by the ALU decoder and the execute stage.
package alu_exec_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT.
// Unknown opcodes yield zero and flag illegal.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with main + skid register and
// a registered in_ready that ignores out_ready.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           alu_control,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] op_count
);

  stage_state_e state;
  stage_state_e state_next;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_illegal;

  logic [WIDTH-1:0] skid_result;
  logic             skid_zero;
  logic             skid_illegal;

  logic in_xfer;
  logic out_xfer;
  logic load_main;
  logic load_skid;
  logic skid_to_main;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_control(alu_control),
    .a          (src_a),
    .b          (src_b),
    .result     (alu_result),
    .zero       (alu_zero),
    .illegal    (alu_illegal)
  );

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_next   = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      op_count <= '0;
    end else begin
      state    <= state_next;
      // Registered ready: next state decides, never out_ready directly
      in_ready <= (state_next != FULL);
      if (out_xfer) op_count <= op_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (load_main) begin
      result  <= alu_result;
      zero    <= alu_zero;
      illegal <= alu_illegal;
    end else if (skid_to_main) begin
      result  <= skid_result;
      zero    <= skid_zero;
      illegal <= skid_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_result  <= '0;
      skid_zero    <= 1'b0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_result  <= alu_result;
      skid_zero    <= alu_zero;
      skid_illegal <= alu_illegal;
    end
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream operation present.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 alu_control  input  4  operation code from the ALU decoder.
REQ-008 src_a  input  WIDTH  operand A.
REQ-009 src_b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  WIDTH  computed value.
REQ-013 zero  output  1  result == 0.
REQ-014 illegal  output  1  operation code unsupported.
REQ-015 op_count  output  CNT_WIDTH  count of results delivered downstream.

Function
REQ-016 Codes: 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0110 SUB (A-B mod 2^WIDTH); 0111 SLT signed two's complement, result 1 or 0 zero-extended.
REQ-017 Any other code: result 0, zero 1, illegal 1; transfer still completes normally.
REQ-018 Input transfer occurs on a cycle with in_valid && in_ready; output transfer occurs on a cycle with out_valid && out_ready.
REQ-019 Result computed combinationally from the accepted inputs and captured at that edge; latency exactly 1 cycle from input transfer to out_valid high when the stage was empty.
REQ-020 Storage: main register plus one skid register; state EMPTY (0 entries), ONE (main only), FULL (main + skid).
REQ-021 in_ready is a registered signal: high in EMPTY and ONE, low in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid high in ONE and FULL; result/zero/illegal always taken from main register.
REQ-023 EMPTY: input transfer -> ONE.
REQ-024 ONE: input only -> FULL (new op into skid); output only -> EMPTY; both -> ONE with new op in main.
REQ-025 FULL: output transfer -> ONE, skid contents move to main; no input accepted.
REQ-026 Output fields SHALL remain stable while out_valid && !out_ready.
REQ-027 Ordering strictly FIFO; no operation dropped or duplicated.
REQ-028 op_count increments by 1 on each output transfer, wraps from all-ones to 0.
REQ-029 Register contents when not valid are don't-care but SHALL NOT leak onto out_valid.

Reset
REQ-030 rst high at an edge: state EMPTY, out_valid 0, in_ready 1 from the next cycle, op_count 0, result 0, zero 0, illegal 0.
REQ-031 rst mid-operation discards main and skid contents; no output transfer counted that cycle; rst has priority over all transfers.

Structure
REQ-032 Shared package holds 4-bit ALU operation code constants (AND, OR, ADD, SUB, SLT) and the storage-state enum; the ALU decoder and this stage both use it.
REQ-033 Combinational arithmetic is one sub-module, alu_core (inputs alu_control, a, b; outputs result, zero, illegal); alu_exec_stage instantiates it once and contains the skid control.

Verification
REQ-034 ADD 0x0000_0005 + 0x0000_0003, out_ready=1 -> next cycle out_valid=1, result 0x0000_0008, zero 0, op_count 1 after transfer.
REQ-035 SUB 0x7 - 0x7 then SLT 0xFFFF_FFFF vs 0x1 -> results 0x0 with zero 1, then 0x1 with zero 0.
REQ-036 out_ready=0, three back-to-back in_valid -> two accepted, in_ready 0 after second; release out_ready -> results in order, third accepted only after first drains.
REQ-037 alu_control 0101 with A=0x1234 -> result 0, zero 1, illegal 1, op_count increments.
REQ-038 ADD 0xFFFF_FFFF + 0x1 -> result 0x0, zero 1; op_count driven past 0xFFFF (CNT_WIDTH 16) -> wraps to 0.
REQ-039 rst asserted in FULL state -> next cycle out_valid 0, in_ready 1, op_count 0; no stale result emitted afterwards.
